// File: rtl/sifive_insight_tl_prot_pkg.sv
// Shared types for the TileLink prot-echo tracker: prot field layout and
// per-source table entry.
package sifive_insight_tl_prot_pkg;

    localparam int PROT_W     = 7;
    localparam int BUFFERABLE = 0;
    localparam int MODIFIABLE = 1;
    localparam int READALLOC  = 2;
    localparam int WRITEALLOC = 3;
    localparam int PRIVILEGED = 4;
    localparam int SECURE     = 5;
    localparam int FETCH      = 6;

    typedef struct packed {
        logic fetch;
        logic secure;
        logic privileged;
        logic writealloc;
        logic readalloc;
        logic modifiable;
        logic bufferable;
    } prot_echo_t;

    typedef struct packed {
        logic       vld;
        prot_echo_t prot;
    } entry_t;

endpackage

// File: rtl/sifive_insight_tl_source_table.sv
// Source-indexed table of outstanding requests: one allocate port, one retire
// port, combinational read of both the allocating and the retiring entry.
import sifive_insight_tl_prot_pkg::*;

module sifive_insight_tl_source_table #(
    parameter int SOURCE_W = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc_en,
    input  logic [SOURCE_W-1:0] alloc_idx,
    input  prot_echo_t          alloc_prot,
    input  logic                ret_en,
    input  logic [SOURCE_W-1:0] ret_idx,
    output logic                alloc_vld,
    output entry_t              ret_entry
);
    localparam int DEPTH = 2 ** SOURCE_W;

    logic       [DEPTH-1:0] vld_q, vld_d;
    prot_echo_t             prot_q [DEPTH];
    prot_echo_t             prot_d [DEPTH];

    assign alloc_vld      = vld_q[alloc_idx];
    assign ret_entry.vld  = vld_q[ret_idx];
    assign ret_entry.prot = prot_q[ret_idx];

    // Retire clears first so a same-cycle allocate to the same source wins.
    always_comb begin
        vld_d  = vld_q;
        prot_d = prot_q;
        if (ret_en)
            vld_d[ret_idx] = 1'b0;
        if (alloc_en) begin
            vld_d[alloc_idx]  = 1'b1;
            prot_d[alloc_idx] = alloc_prot;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    always_ff @(posedge clock) begin
        prot_q <= prot_d;
    end

endmodule

// File: rtl/sifive_insight_tl_prot_echo_tracker.sv
// Records A-channel prot echo per source and replays it, registered, when the
// matching D response completes; flags duplicate sources and orphan responses.
import sifive_insight_tl_prot_pkg::*;

module sifive_insight_tl_prot_echo_tracker #(
    parameter int SOURCE_W = 2,
    parameter int PROT_W   = 7,
    parameter int CNT_W    = SOURCE_W + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    input  logic                a_ready,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [PROT_W-1:0]   a_prot,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic                d_last,
    output logic                trace_valid,
    output logic [SOURCE_W-1:0] trace_source,
    output logic [PROT_W-1:0]   trace_prot,
    output logic                err_dup_source,
    output logic                err_orphan_d,
    output logic [CNT_W-1:0]    outstanding
);
    logic   a_fire, d_ret, same_src, ret_hit, alloc_vld;
    logic   alloc_new, retire_valid;
    entry_t ret_entry;

    logic                trace_valid_q, trace_valid_d;
    logic [SOURCE_W-1:0] trace_source_q, trace_source_d;
    logic [PROT_W-1:0]   trace_prot_q, trace_prot_d;
    logic                err_dup_source_q, err_dup_source_d;
    logic                err_orphan_d_q, err_orphan_d_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;

    assign a_fire   = a_valid & a_ready;
    assign d_ret    = d_valid & d_ready & d_last;
    assign same_src = (a_source == d_source);

    sifive_insight_tl_source_table #(.SOURCE_W(SOURCE_W)) u_table (
        .clock      (clock),
        .reset      (reset),
        .alloc_en   (a_fire),
        .alloc_idx  (a_source),
        .alloc_prot (prot_echo_t'(a_prot)),
        .ret_en     (d_ret),
        .ret_idx    (d_source),
        .alloc_vld  (alloc_vld),
        .ret_entry  (ret_entry)
    );

    // A same-source retire+allocate on a valid entry hands the slot straight
    // over, so neither side moves the counter.
    always_comb begin
        ret_hit          = d_ret & ret_entry.vld;
        alloc_new        = a_fire & ~alloc_vld;
        retire_valid     = ret_hit & ~(a_fire & same_src);
        outstanding_d    = outstanding_q + CNT_W'(alloc_new) - CNT_W'(retire_valid);
        err_dup_source_d = a_fire & alloc_vld & ~(d_ret & same_src);
        err_orphan_d_d   = d_ret & ~ret_entry.vld;
        trace_valid_d    = ret_hit;
        trace_source_d   = ret_hit ? d_source : trace_source_q;
        trace_prot_d     = ret_hit ? PROT_W'(ret_entry.prot) : trace_prot_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trace_valid_q    <= 1'b0;
            trace_source_q   <= '0;
            trace_prot_q     <= '0;
            err_dup_source_q <= 1'b0;
            err_orphan_d_q   <= 1'b0;
            outstanding_q    <= '0;
        end else begin
            trace_valid_q    <= trace_valid_d;
            trace_source_q   <= trace_source_d;
            trace_prot_q     <= trace_prot_d;
            err_dup_source_q <= err_dup_source_d;
            err_orphan_d_q   <= err_orphan_d_d;
            outstanding_q    <= outstanding_d;
        end
    end

    assign trace_valid    = trace_valid_q;
    assign trace_source   = trace_source_q;
    assign trace_prot     = trace_prot_q;
    assign err_dup_source = err_dup_source_q;
    assign err_orphan_d   = err_orphan_d_q;
    assign outstanding    = outstanding_q;

endmodule

// File: tb/tb_sifive_insight_tl_prot_echo_tracker.sv
// Directed bench for the prot echo tracker with hand-computed expectations.
module tb_sifive_insight_tl_prot_echo_tracker;
    logic       clock = 1'b0;
    logic       reset;
    logic       a_valid, a_ready, d_valid, d_ready, d_last;
    logic [1:0] a_source, d_source, trace_source;
    logic [6:0] a_prot, trace_prot;
    logic       trace_valid, err_dup_source, err_orphan_d;
    logic [2:0] outstanding;

    int checks   = 0;
    int failures = 0;

    sifive_insight_tl_prot_echo_tracker dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_source(a_source), .a_prot(a_prot),
        .d_valid(d_valid), .d_ready(d_ready), .d_source(d_source), .d_last(d_last),
        .trace_valid(trace_valid), .trace_source(trace_source), .trace_prot(trace_prot),
        .err_dup_source(err_dup_source), .err_orphan_d(err_orphan_d),
        .outstanding(outstanding)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, pass the edge, and leave outputs settled.
    task automatic cyc(input logic av, input logic ar, input logic [1:0] as, input logic [6:0] ap,
                       input logic dv, input logic [1:0] ds, input logic dl);
        a_valid = av; a_ready = ar; a_source = as; a_prot = ap;
        d_valid = dv; d_ready = 1'b1; d_source = ds; d_last = dl;
        @(posedge clock); #1;
        a_valid = 1'b0; d_valid = 1'b0;
    endtask

    task automatic a_op(input logic [1:0] s, input logic [6:0] p);
        cyc(1'b1, 1'b1, s, p, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic d_op(input logic [1:0] s, input logic l);
        cyc(1'b0, 1'b1, 2'd0, 7'h00, 1'b1, s, l);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 2'd0, 7'h00, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic chk_trace(input string tag, input logic v, input logic [1:0] s, input logic [6:0] p);
        chk({tag, ".tv"}, 32'(trace_valid), 32'(v));
        chk({tag, ".ts"}, 32'(trace_source), 32'(s));
        chk({tag, ".tp"}, 32'(trace_prot), 32'(p));
    endtask

    initial begin
        reset = 1'b1;
        idle(); idle();
        reset = 1'b0;
        chk_trace("rst", 1'b0, 2'd0, 7'h00);
        chk("rst.dup", 32'(err_dup_source), 32'd0);
        chk("rst.orph", 32'(err_orphan_d), 32'd0);
        chk("rst.out", 32'(outstanding), 32'd0);

        // A valid without ready must not allocate
        cyc(1'b1, 1'b0, 2'd1, 7'h33, 1'b0, 2'd0, 1'b0);
        chk("noready.out", 32'(outstanding), 32'd0);

        // Basic echo
        a_op(2'd1, 7'h45);
        chk("basic.out1", 32'(outstanding), 32'd1);
        chk("basic.tv0", 32'(trace_valid), 32'd0);
        idle(); idle(); idle();
        d_op(2'd1, 1'b1);
        chk_trace("basic", 1'b1, 2'd1, 7'h45);
        chk("basic.out0", 32'(outstanding), 32'd0);
        idle();
        chk_trace("hold", 1'b0, 2'd1, 7'h45);

        // Multi-beat D
        a_op(2'd2, 7'h12);
        d_op(2'd2, 1'b0);
        chk("mb.b0.tv", 32'(trace_valid), 32'd0);
        chk("mb.b0.out", 32'(outstanding), 32'd1);
        d_op(2'd2, 1'b0);
        chk("mb.b1.tv", 32'(trace_valid), 32'd0);
        chk("mb.b1.orph", 32'(err_orphan_d), 32'd0);
        d_op(2'd2, 1'b1);
        chk_trace("mb.last", 1'b1, 2'd2, 7'h12);
        chk("mb.out", 32'(outstanding), 32'd0);

        // Same-cycle A and D retire on a valid source
        a_op(2'd3, 7'h01);
        cyc(1'b1, 1'b1, 2'd3, 7'h7F, 1'b1, 2'd3, 1'b1);
        chk_trace("same", 1'b1, 2'd3, 7'h01);
        chk("same.dup", 32'(err_dup_source), 32'd0);
        chk("same.orph", 32'(err_orphan_d), 32'd0);
        chk("same.out", 32'(outstanding), 32'd1);
        d_op(2'd3, 1'b1);
        chk_trace("same.2nd", 1'b1, 2'd3, 7'h7F);
        chk("same.out0", 32'(outstanding), 32'd0);

        // Duplicate source
        a_op(2'd0, 7'h0A);
        a_op(2'd0, 7'h0B);
        chk("dup.pulse", 32'(err_dup_source), 32'd1);
        chk("dup.out", 32'(outstanding), 32'd1);
        idle();
        chk("dup.clear", 32'(err_dup_source), 32'd0);
        d_op(2'd0, 1'b1);
        chk_trace("dup.d", 1'b1, 2'd0, 7'h0B);
        chk("dup.out0", 32'(outstanding), 32'd0);

        // Same-cycle A and D retire on an invalid source
        cyc(1'b1, 1'b1, 2'd1, 7'h5A, 1'b1, 2'd1, 1'b1);
        chk("inv.orph", 32'(err_orphan_d), 32'd1);
        chk("inv.tv", 32'(trace_valid), 32'd0);
        chk("inv.out", 32'(outstanding), 32'd1);
        // Different sources at once: retire 1, allocate 2
        cyc(1'b1, 1'b1, 2'd2, 7'h66, 1'b1, 2'd1, 1'b1);
        chk_trace("diff", 1'b1, 2'd1, 7'h5A);
        chk("diff.out", 32'(outstanding), 32'd1);
        d_op(2'd2, 1'b1);
        chk_trace("diff.d", 1'b1, 2'd2, 7'h66);
        chk("diff.out0", 32'(outstanding), 32'd0);

        // Orphan after reset
        a_op(2'd0, 7'h01); a_op(2'd1, 7'h02); a_op(2'd2, 7'h03); a_op(2'd3, 7'h04);
        chk("orst.out4", 32'(outstanding), 32'd4);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("orst.out0", 32'(outstanding), 32'd0);
        chk_trace("orst", 1'b0, 2'd0, 7'h00);
        d_op(2'd2, 1'b1);
        chk("orst.orph", 32'(err_orphan_d), 32'd1);
        chk("orst.tv", 32'(trace_valid), 32'd0);

        // Fill and drain
        a_op(2'd0, 7'h11); a_op(2'd1, 7'h22); a_op(2'd2, 7'h33); a_op(2'd3, 7'h44);
        chk("fill.out", 32'(outstanding), 32'd4);
        d_op(2'd3, 1'b1);
        chk_trace("drain3", 1'b1, 2'd3, 7'h44);
        chk("drain3.out", 32'(outstanding), 32'd3);
        d_op(2'd1, 1'b1);
        chk_trace("drain1", 1'b1, 2'd1, 7'h22);
        chk("drain1.out", 32'(outstanding), 32'd2);
        d_op(2'd0, 1'b1);
        chk_trace("drain0", 1'b1, 2'd0, 7'h11);
        chk("drain0.out", 32'(outstanding), 32'd1);
        d_op(2'd2, 1'b1);
        chk_trace("drain2", 1'b1, 2'd2, 7'h33);
        chk("drain2.out", 32'(outstanding), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
